// File: rtl/game_pkg.sv
// Shared definitions for the runner game: lane encoding, scheduler states and
// map indexing helpers.
package game_pkg;

  localparam int LANES = 3;
  localparam logic [1:0] LANE_NONE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    WARM,
    READY,
    GATHER,
    SHIFT,
    FROZEN
  } sched_state_e;

  function automatic int unsigned map_idx(input int unsigned row, input int unsigned lane);
    return row * LANES + lane;
  endfunction

  function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] code);
    logic [LANES-1:0] oh;
    oh = '0;
    case (code)
      2'd0:    oh = 3'b001;
      2'd1:    oh = 3'b010;
      2'd2:    oh = 3'b100;
      default: oh = '0;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/map_shifter.sv
// ROWS x LANES obstacle map: row 0 loads on shift while older rows move toward
// the player; produces the spawn/passed pulses for each shift.
module map_shifter
  import game_pkg::*;
#(
  parameter int ROWS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  shift,
  input  logic [LANES-1:0]      row_in,
  output logic [LANES*ROWS-1:0] map,
  output logic                  spawn,
  output logic                  passed
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      map    <= '0;
      spawn  <= 1'b0;
      passed <= 1'b0;
    end else if (shift) begin
      map    <= {map[LANES*(ROWS-1)-1:0], row_in};
      spawn  <= |row_in;
      passed <= |map[map_idx(ROWS-1, 0) +: LANES];
    end else begin
      spawn  <= 1'b0;
      passed <= 1'b0;
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Sequences the LFSR generator (reseed, warm-up) and converts two random bits
// per scroll tick into a new obstacle row for the scrolling map.
module obstacle_scheduler
  import game_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int GAP_MIN = 1,
  parameter int WARMUP  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  freeze,
  input  logic                  tick,
  input  logic                  rand_bit,
  output logic                  rng_start,
  output logic [LANES*ROWS-1:0] obst_map,
  output logic                  spawn,
  output logic                  passed,
  output logic                  busy,
  output logic                  overrun
);

  localparam int GW = (GAP_MIN < 1) ? 1 : $clog2(GAP_MIN + 1);
  localparam int WW = $clog2(WARMUP + 2);

  sched_state_e     state;
  logic [WW-1:0]    warm_cnt;
  logic             bit_cnt;
  logic [1:0]       lane_code;
  logic [GW-1:0]    gap_cnt;
  logic             pending;
  logic             do_shift;
  logic [LANES-1:0] new_row;

  // Shift is suppressed on the edge where freeze or run=0 wins, so an
  // abandoned scroll never leaves a partially moved map.
  assign do_shift = (state == SHIFT) && run && !freeze;

  always_comb begin
    new_row = '0;
    if (gap_cnt == '0) new_row = lane_onehot(lane_code);
  end

  map_shifter #(.ROWS(ROWS)) u_map (
    .clk   (clk),
    .rst   (rst),
    .clear (!run),
    .shift (do_shift),
    .row_in(new_row),
    .map   (obst_map),
    .spawn (spawn),
    .passed(passed)
  );

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      state     <= IDLE;
      rng_start <= 1'b1;
      busy      <= 1'b0;
      overrun   <= 1'b0;
      pending   <= 1'b0;
      gap_cnt   <= '0;
      warm_cnt  <= '0;
      bit_cnt   <= 1'b0;
      lane_code <= '0;
    end else if (freeze && state != IDLE) begin
      state   <= FROZEN;
      busy    <= 1'b0;
      pending <= 1'b0;
      bit_cnt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state     <= WARM;
          rng_start <= 1'b0;
          busy      <= 1'b1;
          warm_cnt  <= '0;
        end
        WARM: begin
          if (warm_cnt == WW'(WARMUP)) begin
            state <= READY;
            busy  <= 1'b0;
          end else begin
            warm_cnt <= warm_cnt + 1'b1;
          end
          if (tick) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
        end
        READY: begin
          if (tick || pending) begin
            state   <= GATHER;
            busy    <= 1'b1;
            bit_cnt <= 1'b0;
            pending <= 1'b0;
            if (tick && pending) overrun <= 1'b1;
          end
        end
        GATHER: begin
          lane_code <= {lane_code[0], rand_bit};
          bit_cnt   <= 1'b1;
          if (bit_cnt) state <= SHIFT;
          if (tick) begin
            if (pending) overrun <= 1'b1;
            else         pending <= 1'b1;
          end
        end
        SHIFT: begin
          if (gap_cnt != '0)             gap_cnt <= gap_cnt - 1'b1;
          else if (lane_code != LANE_NONE) gap_cnt <= GW'(GAP_MIN);
          // A tick landing on the shift cycle chains straight into the next gather.
          if (tick || pending) begin
            state   <= GATHER;
            bit_cnt <= 1'b0;
            pending <= 1'b0;
            if (tick && pending) overrun <= 1'b1;
          end else begin
            state <= READY;
            busy  <= 1'b0;
          end
        end
        FROZEN: state <= FROZEN;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Bench for obstacle_scheduler: directed scroll table, multi-cycle corner
// sequences, then random ticks/bits against a timeline reference model.
module tb_obstacle_scheduler;
  import game_pkg::*;

  localparam int ROWS    = 4;
  localparam int GAP_MIN = 1;
  localparam int WARMUP  = 2;
  localparam int MW      = LANES * ROWS;

  logic          clk = 1'b0;
  logic          rst, run, freeze, tick, rand_bit;
  logic          rng_start, spawn, passed, busy, overrun;
  logic [MW-1:0] obst_map;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  obstacle_scheduler #(.ROWS(ROWS), .GAP_MIN(GAP_MIN), .WARMUP(WARMUP)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .freeze   (freeze),
    .tick     (tick),
    .rand_bit (rand_bit),
    .rng_start(rng_start),
    .obst_map (obst_map),
    .spawn    (spawn),
    .passed   (passed),
    .busy     (busy),
    .overrun  (overrun)
  );

  typedef struct {
    logic          b1;
    logic          b0;
    logic [MW-1:0] map;
    logic          sp;
    logic          ps;
  } scroll_vec_t;

  scroll_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive inputs for one rising edge, then return at the following falling edge.
  task automatic cyc(input logic t, input logic b);
    tick     = t;
    rand_bit = b;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic scroll(input int idx, input logic [MW-1:0] prev_map);
    cyc(1'b1, 1'b0);
    check($sformatf("s%0d_busy_gather", idx), busy, 1);
    cyc(1'b0, vecs[idx].b1);
    check($sformatf("s%0d_busy_bit1", idx), busy, 1);
    cyc(1'b0, vecs[idx].b0);
    check($sformatf("s%0d_map_hold", idx), obst_map, prev_map);
    cyc(1'b0, 1'b0);
    check($sformatf("s%0d_map", idx), obst_map, vecs[idx].map);
    check($sformatf("s%0d_spawn", idx), spawn, vecs[idx].sp);
    check($sformatf("s%0d_passed", idx), passed, vecs[idx].ps);
    check($sformatf("s%0d_busy_done", idx), busy, 0);
    cyc(1'b0, 1'b0);
    check($sformatf("s%0d_pulse_clear", idx), {spawn, passed}, 0);
  endtask

  // Reference model: rows hold a lane number or -1, jobs are tracked by the
  // cycle their tick was accepted.
  int            m_rows[ROWS];
  int            m_gap, m_code, m_start;
  bit            m_job, m_pend, m_ovr;
  logic          m_sp, m_ps;

  function automatic logic [MW-1:0] m_map();
    logic [MW-1:0] m;
    m = '0;
    for (int r = 0; r < ROWS; r++)
      if (m_rows[r] >= 0) m[r*LANES + m_rows[r]] = 1'b1;
    return m;
  endfunction

  task automatic model_edge(input int c, input logic t, input logic b);
    m_sp = 1'b0;
    m_ps = 1'b0;
    if (m_job) begin
      if (c - m_start == 1) m_code = int'(b) * 2;
      else if (c - m_start == 2) m_code = m_code + int'(b);
      else if (c - m_start == 3) begin
        m_ps = (m_rows[ROWS-1] >= 0);
        for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
        if (m_gap > 0) begin
          m_rows[0] = -1;
          m_gap--;
        end else if (m_code == 3) begin
          m_rows[0] = -1;
        end else begin
          m_rows[0] = m_code;
          m_sp      = 1'b1;
          m_gap     = GAP_MIN;
        end
        m_job = 1'b0;
      end
    end
    if (!m_job) begin
      if (t || m_pend) begin
        if (t && m_pend) m_ovr = 1'b1;
        m_job   = 1'b1;
        m_start = c;
        m_pend  = 1'b0;
      end
    end else if (t) begin
      if (m_pend) m_ovr = 1'b1;
      else        m_pend = 1'b1;
    end
  endtask

  initial begin
    logic [MW-1:0] prev;
    logic          t, b;

    vecs[0] = '{1'b0, 1'b1, 12'h002, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 12'h010, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 12'h084, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 12'h420, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 12'h100, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, 12'h801, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 12'h008, 1'b0, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 12'h044, 1'b1, 1'b0};

    rst = 1'b1; run = 1'b0; freeze = 1'b0; tick = 1'b0; rand_bit = 1'b0;
    @(negedge clk);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("rst_outputs", {rng_start, spawn, passed, busy, overrun}, 5'b10000);
    check("rst_map", obst_map, 0);
    rst = 1'b0;

    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    check("idle_tick_map", obst_map, 0);
    check("idle_tick_ctl", {rng_start, busy, spawn}, 3'b100);

    run = 1'b1;
    cyc(1'b0, 1'b0);
    check("run_rng_low", rng_start, 0);
    check("warm_busy0", busy, 1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("warm_busy2", busy, 1);
    cyc(1'b0, 1'b0);
    check("ready_after_warm", busy, 0);

    prev = '0;
    for (int i = 0; i < 8; i++) begin
      scroll(i, prev);
      prev = vecs[i].map;
    end
    check("table_overrun", overrun, 0);

    // Three ticks on consecutive cycles: one runs, one queues, one overruns.
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    check("b2b_no_ovr_yet", overrun, 0);
    cyc(1'b1, 1'b1);
    check("b2b_overrun", overrun, 1);
    cyc(1'b0, 1'b0);
    check("b2b_map1", obst_map, 12'h220);
    check("b2b_busy_chain", busy, 1);
    cyc(1'b0, 1'b0);
    check("b2b_hold_e4", obst_map, 12'h220);
    cyc(1'b0, 1'b1);
    check("b2b_hold_e5", obst_map, 12'h220);
    cyc(1'b0, 1'b0);
    check("b2b_map2", obst_map, 12'h102);
    check("b2b_pulses2", {spawn, passed, busy}, 3'b110);

    // Freeze in the middle of a gather.
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    freeze = 1'b1;
    cyc(1'b0, 1'b1);
    check("frz_busy", busy, 0);
    cyc(1'b0, 1'b0);
    check("frz_map", obst_map, 12'h102);
    check("frz_spawn", spawn, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
    check("frz_ticks_ignored", {obst_map, busy, spawn}, {12'h102, 2'b00});
    check("frz_ovr_sticky", overrun, 1);
    run = 1'b0; freeze = 1'b0;
    cyc(1'b0, 1'b0);
    check("stop_map", obst_map, 0);
    check("stop_ctl", {rng_start, overrun, busy}, 3'b100);

    // Reset arriving on the shift edge.
    run = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    check("rewarm_ready", {busy, rng_start}, 2'b00);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    check("pre_rst_map", obst_map, 12'h001);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b0);
    rst = 1'b1;
    cyc(1'b0, 1'b0);
    check("rst_shift_map", obst_map, 0);
    check("rst_shift_ctl", {rng_start, spawn, passed, busy, overrun}, 5'b10000);
    rst = 1'b0;

    // Random phase.
    run = 1'b0;
    cyc(1'b0, 1'b0);
    run = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
    for (int r = 0; r < ROWS; r++) m_rows[r] = -1;
    m_gap = 0; m_code = 0; m_start = 0; m_job = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
    for (int c = 0; c < 800; c++) begin
      t = ($urandom_range(0, 9) < 3);
      b = 1'($urandom_range(0, 1));
      cyc(t, b);
      model_edge(c, t, b);
      check($sformatf("rand_c%0d", c), {obst_map, spawn, passed, busy, overrun},
            {m_map(), m_sp, m_ps, m_job, m_ovr});
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
